enemy_bullet_ctrl: RTL and testbench
====================================

Name: enemy_bullet_ctrl

Overview:
- Upstream producer of the enemy bullet consumed by the player collision judge.
- Spawns one bullet under a live enemy and moves it down the screen at a fixed tick rate.
- Retires the bullet on screen-bottom exit or on a hit acknowledge from the judge, then enforces a cooldown before the next shot.
- Outputs eb_x/eb_y/eb_en drive the judge's bullet position and enable inputs directly.

Parameters:
STEP_DIV, 250000, clk cycles per movement tick (>=2)
SPEED, 4, pixels added to eb_y per tick (1..31)
COOLDOWN_TICKS, 30, ticks spent in COOL after a bullet retires (>=1)
Y_LIMIT, 480, bottom screen bound; bullet retires when next y >= Y_LIMIT
X_OFFSET, 20, spawn x offset from enemy_x
Y_OFFSET, 40, spawn y offset from enemy_y

Ports:
clk  in  1  system clock; single clock domain
rst  in  1  reset, synchronous, active-high
enemy_x  in  10  enemy plane top-left x
enemy_y  in  10  enemy plane top-left y
enemy_alive  in  1  1 = enemy exists and may fire
fire_en  in  1  1 = game running; 0 aborts and blocks firing
hit_ack  in  1  one-cycle pulse from judge: bullet consumed
eb_x  out  10  bullet x
eb_y  out  10  bullet y
eb_en  out  1  1 = bullet exists
shot_count  out  8  bullets spawned, wraps 255->0

Behaviour:
- Reset (sync, rst=1 at posedge): state=IDLE; eb_x=0, eb_y=0, eb_en=0, shot_count=0; tick counter=0; cooldown counter=0. Reset overrides every other input, including mid-flight.
- Tick: free-running counter 0..STEP_DIV-1; tick=1 for the one cycle the counter equals STEP_DIV-1. Unaffected by state.
- IDLE: eb_en=0.
  - If fire_en && enemy_alive && (enemy_y+Y_OFFSET) < Y_LIMIT (11-bit compare): latch eb_x=enemy_x+X_OFFSET (10-bit, wraps), eb_y=enemy_y+Y_OFFSET, set eb_en=1, shot_count+=1, go FLY. Outputs are visible one cycle after the condition is sampled.
  - Otherwise stay in IDLE.
- FLY: eb_en=1. Priority, highest first:
  - fire_en=0: eb_en=0, go IDLE.
  - hit_ack=1: eb_en=0, go COOL, clear cooldown counter.
  - tick=1 and eb_y+SPEED >= Y_LIMIT (11-bit sum): eb_en=0, go COOL, eb_y unchanged.
  - tick=1: eb_y += SPEED.
  - enemy_alive falling while in FLY does not retire the bullet.
- COOL: eb_en=0.
  - fire_en=0: go IDLE immediately.
  - Otherwise cooldown counter increments on each tick; on the tick that makes it equal COOLDOWN_TICKS, go IDLE.
- eb_x/eb_y hold their last values whenever eb_en=0.
- hit_ack is ignored in IDLE and COOL.
- hit_ack and tick in the same cycle: hit_ack wins; eb_y is not advanced.
- Bottom-exit and hit_ack both lead to COOL with identical cooldown.
- No second bullet exists while one is in FLY.

Optional Feature:
AIMED_SHOT_EN
- Defined: adds input p_x (10 bits, player x). In FLY, on each tick that advances eb_y, eb_x moves 1 pixel toward p_x+X_OFFSET (+1 if less, -1 if greater, hold if equal). The hit_ack/exit priority above is unchanged.
- Undefined: port p_x absent; eb_x is constant for the whole flight.

Test Plan:
- Reset: STEP_DIV=4; rst=1 for 2 cycles with fire_en=1 -> eb_en=0, eb_x=0, eb_y=0, shot_count=0. Release rst -> bullet spawns on the next cycle.
- Spawn and flight: enemy=(100,50), fire_en=1, enemy_alive=1 -> eb_x=120, eb_y=90, eb_en=1, shot_count=1. Then eb_y=94, 98, ... one step every 4 cycles.
- Bottom exit: eb_y=476, SPEED=4 -> at the next tick eb_en=0, eb_y stays 476. COOLDOWN_TICKS=3 -> respawn 3 ticks later (12 cycles, with a phase tolerance of one tick).
- Hit: hit_ack pulse in the same cycle as a tick with eb_y=200 -> eb_en=0 the next cycle, eb_y=200, state COOL.
- Abort: fire_en=0 mid-FLY -> eb_en=0 next cycle. fire_en=1 again -> immediate spawn, no cooldown applied.
- Wrap and guard: preload 255 shots, spawn one more -> shot_count=0. enemy_y=445 (445+40=485 >= 480) -> no spawn, eb_en stays 0.

Source files
------------

// File: rtl/enemy_bullet_ctrl_if.sv
// Bundle between the enemy bullet controller and its environment (enemy, game state, collision judge).
// AIMED_SHOT_EN adds the player x position p_x.
interface enemy_bullet_ctrl_if;
    logic [9:0] enemy_x;
    logic [9:0] enemy_y;
    logic       enemy_alive;
    logic       fire_en;
    logic       hit_ack;
`ifdef AIMED_SHOT_EN
    logic [9:0] p_x;
`endif
    logic [9:0] eb_x;
    logic [9:0] eb_y;
    logic       eb_en;
    logic [7:0] shot_count;

    modport master (
`ifdef AIMED_SHOT_EN
        output p_x,
`endif
        output enemy_x, enemy_y, enemy_alive, fire_en, hit_ack,
        input  eb_x, eb_y, eb_en, shot_count
    );

    modport slave (
`ifdef AIMED_SHOT_EN
        input  p_x,
`endif
        input  enemy_x, enemy_y, enemy_alive, fire_en, hit_ack,
        output eb_x, eb_y, eb_en, shot_count
    );
endinterface

// File: rtl/enemy_bullet_ctrl.sv
// Enemy bullet: spawn under a live enemy, fall at a fixed tick rate, retire on exit/hit, then cool down.
// Optional AIMED_SHOT_EN: bullet x drifts one pixel per tick toward the player.
module enemy_bullet_ctrl #(
    parameter int STEP_DIV       = 250000,
    parameter int SPEED          = 4,
    parameter int COOLDOWN_TICKS = 30,
    parameter int Y_LIMIT        = 480,
    parameter int X_OFFSET       = 20,
    parameter int Y_OFFSET       = 40
) (
    input  logic                clk,
    input  logic                rst,
    enemy_bullet_ctrl_if.slave  eb_bus
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FLY,
        ST_COOL
    } state_t;

    localparam int TICK_W = $clog2(STEP_DIV);
    localparam int COOL_W = $clog2(COOLDOWN_TICKS + 1);

    state_t              r_state;
    state_t              w_next_state;
    logic [TICK_W-1:0]   r_tick_cnt;
    logic [COOL_W-1:0]   r_cool_cnt;
    logic [9:0]          r_eb_x;
    logic [9:0]          r_eb_y;
    logic [7:0]          r_shot_count;
    logic                w_eb_en;
    logic                w_tick;
    logic [10:0]         w_spawn_y;
    logic [10:0]         w_step_y;
    logic                w_can_fire;
    logic                w_hits_bottom;
    logic                w_cool_done;

    assign w_tick        = (r_tick_cnt == TICK_W'(STEP_DIV - 1));
    // Both sums are 11 bits so a position near 1023 cannot wrap past the bound.
    assign w_spawn_y     = {1'b0, eb_bus.enemy_y} + 11'(Y_OFFSET);
    assign w_step_y      = {1'b0, r_eb_y} + 11'(SPEED);
    assign w_can_fire    = eb_bus.fire_en && eb_bus.enemy_alive && (w_spawn_y < 11'(Y_LIMIT));
    assign w_hits_bottom = (w_step_y >= 11'(Y_LIMIT));
    assign w_cool_done   = w_tick && (r_cool_cnt == COOL_W'(COOLDOWN_TICKS - 1));

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: next state defaults to the current state so no path through this block infers a latch.
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (w_can_fire) w_next_state = ST_FLY;
            end
            ST_FLY: begin
                if (!eb_bus.fire_en)                w_next_state = ST_IDLE;
                else if (eb_bus.hit_ack)            w_next_state = ST_COOL;
                else if (w_tick && w_hits_bottom)   w_next_state = ST_COOL;
            end
            ST_COOL: begin
                if (!eb_bus.fire_en)                w_next_state = ST_IDLE;
                else if (w_cool_done)               w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        w_eb_en = (r_state == ST_FLY);
    end

`ifdef AIMED_SHOT_EN
    logic [9:0] w_aim_x;
    assign w_aim_x = eb_bus.p_x + 10'(X_OFFSET);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_eb_x       <= '0;
            r_eb_y       <= '0;
            r_shot_count <= '0;
            r_cool_cnt   <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_can_fire) begin
                        r_eb_x       <= eb_bus.enemy_x + 10'(X_OFFSET);
                        r_eb_y       <= w_spawn_y[9:0];
                        r_shot_count <= r_shot_count + 1'b1;
                    end
                end
                ST_FLY: begin
                    // Abort leaves position untouched; hit and bottom exit share one cooldown.
                    if (!eb_bus.fire_en) begin
                        r_cool_cnt <= '0;
                    end else if (eb_bus.hit_ack) begin
                        r_cool_cnt <= '0;
                    end else if (w_tick) begin
                        if (w_hits_bottom) begin
                            r_cool_cnt <= '0;
                        end else begin
                            r_eb_y <= w_step_y[9:0];
`ifdef AIMED_SHOT_EN
                            if (r_eb_x < w_aim_x)      r_eb_x <= r_eb_x + 1'b1;
                            else if (r_eb_x > w_aim_x) r_eb_x <= r_eb_x - 1'b1;
`endif
                        end
                    end
                end
                ST_COOL: begin
                    if (eb_bus.fire_en && w_tick) r_cool_cnt <= r_cool_cnt + 1'b1;
                end
                default: r_cool_cnt <= '0;
            endcase
        end
    end

    assign eb_bus.eb_x       = r_eb_x;
    assign eb_bus.eb_y       = r_eb_y;
    assign eb_bus.eb_en      = w_eb_en;
    assign eb_bus.shot_count = r_shot_count;

endmodule

// File: tb/tb_enemy_bullet_ctrl.sv
// Self-checking bench for enemy_bullet_ctrl: directed scenarios plus randomized play checked
// every cycle against a bullet-lifetime model kept in plain integers.
module tb_enemy_bullet_ctrl;

    localparam int SD = 4;
    localparam int SP = 4;
    localparam int CT = 3;
    localparam int YL = 480;
    localparam int XO = 20;
    localparam int YO = 40;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    enemy_bullet_ctrl_if bus ();

    enemy_bullet_ctrl #(
        .STEP_DIV       (SD),
        .SPEED          (SP),
        .COOLDOWN_TICKS (CT),
        .Y_LIMIT        (YL),
        .X_OFFSET       (XO),
        .Y_OFFSET       (YO)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .eb_bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Model: a bullet is either alive, cooling for some remaining ticks, or absent.
    bit m_en        = 1'b0;
    int m_x         = 0;
    int m_y         = 0;
    int m_count     = 0;
    int m_cool_left = 0;
    int m_cyc       = 0;
    bit m_tick;
    int m_tgt;

    always @(posedge clk) begin
        if (rst) begin
            m_en = 0; m_x = 0; m_y = 0; m_count = 0; m_cool_left = 0; m_cyc = 0;
        end else begin
            m_tick = ((m_cyc % SD) == SD - 1);
            m_cyc++;
            if (m_en) begin
                if (!bus.fire_en) begin
                    m_en = 0;
                end else if (bus.hit_ack) begin
                    m_en = 0; m_cool_left = CT;
                end else if (m_tick) begin
                    if (m_y + SP >= YL) begin
                        m_en = 0; m_cool_left = CT;
                    end else begin
                        m_y = m_y + SP;
`ifdef AIMED_SHOT_EN
                        m_tgt = (int'(bus.p_x) + XO) % 1024;
                        if (m_x < m_tgt) m_x = m_x + 1;
                        else if (m_x > m_tgt) m_x = m_x - 1;
`endif
                    end
                end
            end else if (m_cool_left > 0) begin
                if (!bus.fire_en) m_cool_left = 0;
                else if (m_tick) m_cool_left = m_cool_left - 1;
            end else if (bus.fire_en && bus.enemy_alive && (int'(bus.enemy_y) + YO < YL)) begin
                m_en    = 1;
                m_x     = (int'(bus.enemy_x) + XO) % 1024;
                m_y     = int'(bus.enemy_y) + YO;
                m_count = (m_count + 1) % 256;
            end
        end
    end

    bit chk_on = 1'b0;

    always @(negedge clk) begin
        if (chk_on) begin
            check("eb_en", int'(bus.eb_en), int'(m_en));
            check("eb_x", int'(bus.eb_x), m_x);
            check("eb_y", int'(bus.eb_y), m_y);
            check("shot_count", int'(bus.shot_count), m_count);
        end
    end

    int budget;
    int low;

    initial begin
        rst             = 1'b1;
        bus.fire_en     = 1'b1;
        bus.enemy_alive = 1'b1;
        bus.enemy_x     = 10'd100;
        bus.enemy_y     = 10'd50;
        bus.hit_ack     = 1'b0;
`ifdef AIMED_SHOT_EN
        bus.p_x         = 10'd100;
`endif
        // Reset held two cycles with firing requested
        @(negedge clk);
        chk_on = 1'b1;
        @(negedge clk);
        check("rst_eb_en", int'(bus.eb_en), 0);
        check("rst_eb_x", int'(bus.eb_x), 0);
        check("rst_eb_y", int'(bus.eb_y), 0);
        check("rst_shots", int'(bus.shot_count), 0);

        // Spawn right after release, then fall 4 px per 4 cycles
        rst = 1'b0;
        @(negedge clk);
        check("spawn_en", int'(bus.eb_en), 1);
        check("spawn_x", int'(bus.eb_x), 120);
        check("spawn_y", int'(bus.eb_y), 90);
        check("spawn_shots", int'(bus.shot_count), 1);
        repeat (3) @(negedge clk);
        check("fly_y1", int'(bus.eb_y), 94);
        repeat (4) @(negedge clk);
        check("fly_y2", int'(bus.eb_y), 98);

        // Abort then immediate respawn
        bus.fire_en = 1'b0;
        @(negedge clk);
        check("abort_en", int'(bus.eb_en), 0);
        bus.fire_en = 1'b1;
        @(negedge clk);
        check("respawn_en", int'(bus.eb_en), 1);
        check("respawn_shots", int'(bus.shot_count), 2);

        // Hit coinciding with a tick at y=200
        bus.fire_en = 1'b0;
        @(negedge clk);
        bus.enemy_y = 10'd60;
        bus.fire_en = 1'b1;
        @(negedge clk);
        budget = 400;
        while (!(m_en && m_y == 200 && (m_cyc % SD) == SD - 1) && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check("hit_reach_in_time", int'(budget > 0), 1);
        check("hit_pre_y", int'(bus.eb_y), 200);
        bus.hit_ack = 1'b1;
        @(negedge clk);
        bus.hit_ack = 1'b0;
        check("hit_en", int'(bus.eb_en), 0);
        check("hit_y", int'(bus.eb_y), 200);
        repeat (3) @(negedge clk);
        check("hit_cooling", int'(bus.eb_en), 0);

        // Bottom exit from y=476 and cooldown length
        bus.fire_en = 1'b0;
        @(negedge clk);
        bus.enemy_y = 10'd396;
        bus.fire_en = 1'b1;
        budget = 400;
        while (!(m_en && m_y == 476) && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check("exit_reach_in_time", int'(budget > 0), 1);
        check("exit_pre_y", int'(bus.eb_y), 476);
        budget = 20;
        while (bus.eb_en && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check("exit_in_time", int'(budget > 0), 1);
        check("exit_y_held", int'(bus.eb_y), 476);
        low = 1;
        while (!bus.eb_en && low < 40) begin
            @(negedge clk);
            if (!bus.eb_en) low++;
        end
        check("cooldown_len_ok", int'(low >= 12 && low <= 16), 1);

        // Shot counter wrap 255 -> 0
        budget = 600;
        while (m_count != 255 && budget > 0) begin
            bus.fire_en = 1'b0;
            @(negedge clk);
            bus.fire_en = 1'b1;
            @(negedge clk);
            budget--;
        end
        check("preload_in_time", int'(budget > 0), 1);
        bus.fire_en = 1'b0;
        @(negedge clk);
        bus.fire_en = 1'b1;
        @(negedge clk);
        check("wrap_shots", int'(bus.shot_count), 0);
        check("wrap_en", int'(bus.eb_en), 1);

        // Spawn guard at and below the bottom bound
        bus.fire_en = 1'b0;
        @(negedge clk);
        bus.enemy_y = 10'd445;
        bus.fire_en = 1'b1;
        repeat (10) @(negedge clk);
        check("guard_445", int'(bus.eb_en), 0);
        bus.enemy_y = 10'd440;
        repeat (6) @(negedge clk);
        check("guard_440", int'(bus.eb_en), 0);
        bus.enemy_y = 10'd439;
        @(negedge clk);
        check("guard_439_en", int'(bus.eb_en), 1);
        check("guard_439_y", int'(bus.eb_y), 479);

        // Randomized play
        for (int i = 0; i < 4000; i++) begin
            rst             = ($urandom_range(0, 499) == 0);
            bus.fire_en     = ($urandom_range(0, 99) < 96);
            bus.enemy_alive = ($urandom_range(0, 99) < 85);
            bus.hit_ack     = ($urandom_range(0, 99) < 3);
            bus.enemy_x     = 10'($urandom_range(0, 1023));
            bus.enemy_y     = 10'($urandom_range(0, 470));
`ifdef AIMED_SHOT_EN
            bus.p_x         = 10'($urandom_range(0, 1023));
`endif
            @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
